// File: rtl/des_round_ctrl.sv
// Round sequencer for the iterative DES core: handshake, round count, key-shift schedule, result register.
// Optional decrypt support is enabled by defining DES_ROUND_CTRL_DECRYPT_EN.
module des_round_ctrl #(
  parameter int CIPHER_WIDTH = 64,
  parameter int ROUND_NUM    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_decrypt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CIPHER_WIDTH-1:0] out_data,
  output logic                    dp_load,
  output logic                    dp_round_en,
  output logic [3:0]              dp_round_idx,
  output logic [1:0]              dp_shift_amt,
  output logic                    dp_shift_dir,
  output logic                    dp_out_en,
  input  logic [CIPHER_WIDTH-1:0] dp_result,
  output logic                    busy
);

  // state | meaning
  // IDLE  | waiting for a block
  // ROUND | datapath runs one round per cycle, idx = cnt
  // FINAL | capture final-transposed result into out_data
  // DONE  | out_data valid, waiting for out_ready
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUND_NUM - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       mode;
  logic       accept;

`ifdef DES_ROUND_CTRL_DECRYPT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode <= 1'b0;
    end else if (accept) begin
      mode <= in_decrypt;
    end
  end
`else
  logic unused_in_decrypt;
  assign unused_in_decrypt = in_decrypt;
  assign mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'd0;
      end else if (state == ROUND && cnt != LAST_ROUND) begin
        cnt <= cnt + 4'd1;
      end
      if (state == FINAL) begin
        out_data <= dp_result;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || (state == DONE && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (cnt == LAST_ROUND) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = ROUND;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dp_load      = accept;
  assign dp_round_en  = (state == ROUND);
  assign dp_round_idx = dp_round_en ? cnt : 4'd0;
  assign dp_out_en    = (state == FINAL);
  assign out_valid    = (state == DONE);
  assign busy         = (state != IDLE);
  assign dp_shift_dir = dp_round_en && mode;

  // Decrypt walks the encrypt rotations backwards, so its first round needs no rotation.
  always_comb begin
    dp_shift_amt = 2'd0;
    if (dp_round_en) begin
      if (cnt == 4'd0 || cnt == 4'd1 || cnt == 4'd8 || cnt == LAST_ROUND) begin
        dp_shift_amt = 2'd1;
      end else begin
        dp_shift_amt = 2'd2;
      end
      if (mode && cnt == 4'd0) begin
        dp_shift_amt = 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl with a small Feistel reference datapath driven by the controller.
module tb_des_round_ctrl;

`ifdef DES_ROUND_CTRL_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_decrypt = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, dp_load, dp_round_en, dp_shift_dir, dp_out_en, busy;
  logic [63:0] out_data, dp_result;
  logic [3:0]  dp_round_idx;
  logic [1:0]  dp_shift_amt;

  logic [63:0] in_block = '0;
  logic [55:0] in_key = '0;

  int n_chk = 0;
  int n_fail = 0;
  int enc_amt [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_round_ctrl #(.CIPHER_WIDTH(64), .ROUND_NUM(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .dp_load(dp_load), .dp_round_en(dp_round_en),
    .dp_round_idx(dp_round_idx), .dp_shift_amt(dp_shift_amt),
    .dp_shift_dir(dp_shift_dir), .dp_out_en(dp_out_en),
    .dp_result(dp_result), .busy(busy)
  );

  function automatic logic [27:0] rot28(logic [27:0] x, int n, bit right);
    int m;
    m = right ? (28 - (n % 28)) % 28 : n % 28;
    return (x << m) | (x >> ((28 - m) % 28));
  endfunction

  function automatic logic [31:0] f_round(logic [31:0] r, logic [55:0] k);
    return ((r ^ k[31:0]) * 32'h9E3779B1) ^ {8'h00, k[55:32]} ^ (r >> 7);
  endfunction

  // Reference datapath: Feistel rounds, key halves rotated before each round.
  logic [31:0] dl, dr;
  logic [27:0] dc, dd, dcn, ddn;
  always_comb begin
    dcn = rot28(dc, int'(dp_shift_amt), dp_shift_dir);
    ddn = rot28(dd, int'(dp_shift_amt), dp_shift_dir);
  end
  always_ff @(posedge clk) begin
    if (dp_load) begin
      dl <= in_block[63:32];
      dr <= in_block[31:0];
      dc <= in_key[55:28];
      dd <= in_key[27:0];
    end else if (dp_round_en) begin
      dl <= dr;
      dr <= dl ^ f_round(dr, {dcn, ddn});
      dc <= dcn;
      dd <= ddn;
    end
  end
  assign dp_result = {dr, dl};

  // Model: subkeys from cumulative encrypt rotations; decrypt uses them in reverse order.
  function automatic logic [63:0] ref_model(logic [63:0] blk, logic [55:0] key, bit dec);
    logic [55:0] sk [16];
    logic [31:0] l, r, t;
    int cum;
    cum = 0;
    for (int i = 0; i < 16; i++) begin
      cum += enc_amt[i];
      sk[i] = {rot28(key[55:28], cum, 1'b0), rot28(key[27:0], cum, 1'b0)};
    end
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_round(r, (dec && DEC_EN) ? sk[15-i] : sk[i]);
      l = t;
    end
    return {r, l};
  endfunction

  function automatic int exp_amt(int i, bit dec);
    if (dec && DEC_EN) return (i == 0) ? 0 : enc_amt[16-i];
    return enc_amt[i];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input int start, input string nm);
    int cyc;
    cyc = start;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, 64'(cyc), 64'd18);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_dp_load"}, dp_load, 0);
    chk({nm, "_round_en"}, dp_round_en, 0);
    chk({nm, "_round_idx"}, dp_round_idx, 0);
    chk({nm, "_shift_amt"}, dp_shift_amt, 0);
    chk({nm, "_shift_dir"}, dp_shift_dir, 0);
    chk({nm, "_out_en"}, dp_out_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_in_ready"}, in_ready, 1);
  endtask

  task automatic do_block(input logic [63:0] blk, input logic [55:0] key, input bit dec,
                          input int stall, input logic [63:0] exp);
    int sum;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_block = blk; in_key = key; in_decrypt = dec; in_valid = 1'b1; out_ready = 1'b0;
    #1 chk("dp_load", dp_load, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_decrypt = ~dec;
    sum = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("round_en", dp_round_en, 1);
      chk("round_idx", dp_round_idx, 64'(k - 1));
      chk("shift_amt", dp_shift_amt, 64'(exp_amt(k - 1, dec)));
      chk("shift_dir", dp_shift_dir, 64'(dec && DEC_EN));
      sum += int'(dp_shift_amt);
    end
    chk("amt_sum", 64'(sum), (dec && DEC_EN) ? 64'd27 : 64'd28);
    @(negedge clk);
    chk("out_en", dp_out_en, 1);
    chk("out_valid_early", out_valid, 0);
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    chk("drain_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] blk;
    logic [55:0] key;
    bit          dec;
    int          stall;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c0, p0, a_blk, b_blk, rblk;
    logic [55:0] rkey;
    logic [63:0] bb [3];
    bit          rdec;

    tbl[0] = '{blk: 64'h0123456789ABCDEF, key: 56'h133457799BBCDF, dec: 1'b0, stall: 0, exp: '0};
    tbl[1] = '{blk: 64'h0000000000000000, key: 56'h00000000000000, dec: 1'b0, stall: 2, exp: '0};
    tbl[2] = '{blk: 64'hFFFFFFFFFFFFFFFF, key: 56'hFFFFFFFFFFFFFF, dec: 1'b1, stall: 1, exp: '0};
    tbl[3] = '{blk: 64'h85E813540F0AB405, key: 56'h133457799BBCDF, dec: 1'b1, stall: 0, exp: '0};
    tbl[4] = '{blk: 64'hDEADBEEFCAFEF00D, key: 56'h0F1E2D3C4B5A69, dec: 1'b0, stall: 3, exp: '0};
    tbl[5] = '{blk: 64'h0123456789ABCDEF, key: 56'h00000000000001, dec: 1'b1, stall: 0, exp: '0};
    foreach (tbl[i]) tbl[i].exp = ref_model(tbl[i].blk, tbl[i].key, tbl[i].dec);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    foreach (tbl[i]) do_block(tbl[i].blk, tbl[i].key, tbl[i].dec, tbl[i].stall, tbl[i].exp);

    // Encrypt then decrypt with the same key must round-trip when decrypt is built in.
    c0 = ref_model(64'h0123456789ABCDEF, 56'h133457799BBCDF, 1'b0);
    do_block(64'h0123456789ABCDEF, 56'h133457799BBCDF, 1'b0, 0, c0);
    p0 = ref_model(c0, 56'h133457799BBCDF, 1'b1);
    do_block(c0, 56'h133457799BBCDF, 1'b1, 0, p0);
`ifdef DES_ROUND_CTRL_DECRYPT_EN
    chk("roundtrip", out_data, 64'h0123456789ABCDEF);
`endif

    // Backpressure with a new block waiting.
    a_blk = 64'h1122334455667788;
    b_blk = 64'h99AABBCCDDEEFF00;
    @(negedge clk);
    in_block = a_blk; in_key = 56'h0A0B0C0D0E0F10; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(0, "bp_latency_a");
    in_block = b_blk; in_valid = 1'b1;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, ref_model(a_blk, 56'h0A0B0C0D0E0F10, 1'b0));
      chk("bp_in_ready", in_ready, 0);
      chk("bp_dp_load", dp_load, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    chk("bp_release_load", dp_load, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 0);
    chk("bp_next_round", dp_round_en, 1);
    chk("bp_next_idx", dp_round_idx, 0);
    wait_valid(1, "bp_latency_b");
    chk("bp_data_b", out_data, ref_model(b_blk, 56'h0A0B0C0D0E0F10, 1'b0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-to-back: three blocks, no idle cycles.
    for (int i = 0; i < 3; i++) bb[i] = {$urandom, $urandom};
    @(negedge clk);
    out_ready = 1'b1; in_block = bb[0]; in_key = 56'h13579BDF02468A; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 54; k++) begin
      @(negedge clk);
      chk("b2b_valid", out_valid, 64'(k % 18 == 0));
      if (k % 18 == 0) begin
        chk("b2b_data", out_data, ref_model(bb[k/18-1], 56'h13579BDF02468A, 1'b0));
        chk("b2b_in_ready", in_ready, 1);
        if (k < 54) in_block = bb[k/18];
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_idle", busy, 0);
    out_ready = 1'b0;

    // Reset at round index 7.
    @(negedge clk);
    in_block = 64'hA5A5A5A55A5A5A5A; in_key = 56'h0123456789ABCD; in_decrypt = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_idx", dp_round_idx, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    do_block(64'hA5A5A5A55A5A5A5A, 56'h0123456789ABCD, 1'b0, 1,
             ref_model(64'hA5A5A5A55A5A5A5A, 56'h0123456789ABCD, 1'b0));

    // Randomized blocks against the model.
    for (int i = 0; i < 20; i++) begin
      rblk = {$urandom, $urandom};
      rkey = 56'({$urandom, $urandom});
      rdec = 1'($urandom_range(0, 1));
      do_block(rblk, rkey, rdec, int'($urandom_range(0, 3)), ref_model(rblk, rkey, rdec));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencer for the iterative DES core. It accepts a block and key over a valid/ready handshake and steps the shared round datapath through the DES schedule: load (initial transposition and PC-1), 16 rounds, then final transposition. It drives the per-round key-shift schedule and holds the result in an output register until downstream accepts it. It sits between the host interface and the datapath (initial/final transposition, round function, key register), which contains no control logic of its own.

## Interface
- CIPHER_WIDTH, 64, width of data block and result register
- ROUND_NUM, 16, round count; fixed at 16 because the shift schedule is DES-specific

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  host presents block+key (block/key go directly to datapath)
- in_ready  out  1  controller can accept
- in_decrypt  in  1  mode for presented block, sampled on accept
- out_valid  out  1  out_data holds a finished block
- out_ready  in  1  downstream accepts out_data
- out_data  out  CIPHER_WIDTH  registered result
- dp_load  out  1  datapath captures IP(in_data) and PC-1(key) this edge
- dp_round_en  out  1  datapath executes one round this edge
- dp_round_idx  out  4  current round, 0..15
- dp_shift_amt  out  2  key rotation amount for this round (0, 1 or 2)
- dp_shift_dir  out  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
- dp_out_en  out  1  controller captures dp_result into out_data this edge
- dp_result  in  CIPHER_WIDTH  final-transposed output of datapath
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, ROUND, FINAL, DONE.
- Accept means in_valid & in_ready.
- in_ready is combinational: (state==IDLE) | (state==DONE & out_ready).
- dp_load = accept, combinational.
- On accept:
  - mode register <= in_decrypt.
  - round counter <= 0.
  - state <= ROUND.
- ROUND:
  - dp_round_en=1; dp_round_idx = counter.
  - Counter increments each cycle.
  - At counter==15, next state is FINAL.
- FINAL:
  - dp_out_en=1; out_data <= dp_result.
  - Next state is DONE.
- DONE:
  - out_valid=1.
  - If out_ready & in_valid: new accept, go to ROUND (out_valid drops next cycle).
  - If out_ready & !in_valid: go to IDLE.
  - Otherwise stay; out_data is held stable.
- Shift schedule, encrypt (dir=0): amt=1 at idx 0,1,8,15; otherwise 2.
- Shift schedule, decrypt (dir=1): amt=0 at idx 0; 1 at idx 1,8,15; 2 otherwise.
- Total rotation over 16 rounds is 28 for encrypt and 27 for decrypt.
- dp_shift_amt and dp_shift_dir are 0 whenever dp_round_en=0.
- The counter saturates logic to 4 bits; no wrap beyond 15 is reachable.
- in_decrypt is ignored outside accept cycles; a mode change mid-operation has no effect.
- Reset (rst_n=0 at an edge), including mid-round or in DONE:
  - state=IDLE, counter=0, mode=0, out_data=0.
  - The in-flight block is discarded.
  - The datapath is not cleared by this block.

## Timing
- Reset values:
  - out_valid=0, out_data=0, dp_load=0, dp_round_en=0, dp_round_idx=0, dp_shift_amt=0, dp_shift_dir=0, dp_out_en=0, busy=0.
  - in_ready=1 once rst_n=1.
- Accept at cycle T:
  - dp_load in T.
  - dp_round_en in T+1..T+16 with idx 0..15.
  - dp_out_en in T+17.
  - out_valid from T+18.
- Latency is 18 cycles accept-to-out_valid.
- Throughput with out_ready and in_valid held high: one block per 18 cycles. Accept occurs in the DONE cycle, so there are no idle cycles.
- out_valid/out_data obey valid/ready: once out_valid=1, it stays 1 and out_data is unchanged until out_ready=1.
- All outputs except in_ready and dp_load are functions of registered state only.

## Configuration
- DES_ROUND_CTRL_DECRYPT_EN defined:
  - in_decrypt is sampled into the mode register.
  - The decrypt schedule and dp_shift_dir=1 are supported.
- Not defined:
  - The mode register is absent and in_decrypt is ignored.
  - dp_shift_dir is tied 0; only the encrypt schedule is generated.

## Test plan
- Reset then single encrypt: with reference datapath, key 133457799BBCDFF1 and block 0123456789ABCDEF. Required: out_valid at T+18 and out_data=85E813540F0AB405.
- Shift schedule: monitor the 16 round cycles. Required: encrypt amt sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28), dir=0. With macro and in_decrypt=1: sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 27), dir=1. Decrypting 85E813540F0AB405 yields 0123456789ABCDEF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_valid, out_data and in_ready=0 stable. in_valid=1 is not accepted until the out_ready=1 cycle.
- Back-to-back: in_valid and out_ready held high for 3 blocks. Required: out_valid pulses at T+18, T+36, T+54, each for one cycle, with correct data.
- Reset mid-operation: rst_n=0 at round idx 7 for one edge. Required: next cycle state IDLE, all outputs at reset values, in_ready=1; a subsequent block completes correctly.
- Mode ignore: without macro, apply in_decrypt=1. Required: dp_shift_dir stays 0 and the encrypt result is produced.
